// File: rtl/pll_lock_ctrl.sv
// PLL bring-up and lock-detect controller: sequences detector reset, charge-pump settling,
// then qualifies lock/loss-of-lock from per-reference-window UP/DOWN mismatch counts.
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 8,
    parameter int SETTLE_CYCLES = 256,
    parameter int ERR_MAX       = 2,
    parameter int LOCK_COUNT    = 64,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic       CLK,
    input  logic       RSTb,
    input  logic       EN,
    input  logic       REF_TICK,
    input  logic       UP,
    input  logic       DOWN,
    output logic       PFD_RSTb,
    output logic       CP_EN,
    output logic       LOCK,
    output logic       LOL,
    output logic [2:0] STATE,
    inout  wire        VDD,
    inout  wire        VSS
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PFD_RST = 3'd1,
        SETTLE  = 3'd2,
        ACQUIRE = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    localparam int             EW      = $clog2(ERR_MAX + 2);
    localparam logic [EW-1:0]  ERR_SAT = EW'(ERR_MAX + 1);
    localparam logic [EW-1:0]  ERR_LIM = EW'(ERR_MAX);

    // Supplies are pass-through pins only; no logic depends on them.
    wire unused_supply;
    assign unused_supply = VDD ^ VSS;

    state_t        state_q, state_d;
    logic          up_meta_q, up_s_q, dn_meta_q, dn_s_q;
    logic [EW-1:0] err_q, err_d, err_total;
    logic [15:0]   timer_q, timer_d;
    logic [7:0]    run_q, run_d, run_inc;
    logic          pfd_rstb_q, cp_en_q, lock_q, lol_q, lol_d;
    logic          mismatch, window_dirty;

    always_comb begin
        mismatch     = up_s_q ^ dn_s_q;
        err_total    = (mismatch && (err_q != ERR_SAT)) ? err_q + EW'(1) : err_q;
        window_dirty = (err_total > ERR_LIM);
        run_inc      = run_q + 8'd1;

        state_d = state_q;
        timer_d = timer_q;
        run_d   = run_q;
        lol_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (EN) state_d = PFD_RST;
            end
            PFD_RST: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == 16'(RST_CYCLES - 1)) state_d = SETTLE;
            end
            SETTLE: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == 16'(SETTLE_CYCLES - 1)) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (REF_TICK) begin
                    if (window_dirty) begin
                        run_d = 8'd0;
                    end else begin
                        run_d = run_inc;
                        if (run_inc == 8'(LOCK_COUNT)) state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (REF_TICK) begin
                    if (window_dirty) begin
                        run_d = run_inc;
                        if (run_inc == 8'(UNLOCK_COUNT)) begin
                            state_d = ACQUIRE;
                            lol_d   = 1'b1;
                        end
                    end else begin
                        run_d = 8'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping EN wins over any lock/unlock decision made this cycle.
        if (!EN && (state_q != IDLE)) begin
            state_d = IDLE;
            lol_d   = 1'b0;
        end

        if (state_d != state_q) begin
            timer_d = 16'd0;
            run_d   = 8'd0;
        end

        // A mismatch on the REF_TICK cycle is already folded into err_total.
        err_d = REF_TICK ? '0 : err_total;
        if ((state_d == ACQUIRE) && (state_q != ACQUIRE)) err_d = '0;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q    <= IDLE;
            up_meta_q  <= 1'b0;
            up_s_q     <= 1'b0;
            dn_meta_q  <= 1'b0;
            dn_s_q     <= 1'b0;
            err_q      <= '0;
            timer_q    <= 16'd0;
            run_q      <= 8'd0;
            pfd_rstb_q <= 1'b0;
            cp_en_q    <= 1'b0;
            lock_q     <= 1'b0;
            lol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            up_meta_q  <= UP;
            up_s_q     <= up_meta_q;
            dn_meta_q  <= DOWN;
            dn_s_q     <= dn_meta_q;
            err_q      <= err_d;
            timer_q    <= timer_d;
            run_q      <= run_d;
            // Outputs decoded from next state so they change on the same edge as STATE.
            pfd_rstb_q <= (state_d == SETTLE) || (state_d == ACQUIRE) || (state_d == LOCKED);
            cp_en_q    <= (state_d == SETTLE) || (state_d == ACQUIRE) || (state_d == LOCKED);
            lock_q     <= (state_d == LOCKED);
            lol_q      <= lol_d;
        end
    end

    assign STATE    = state_q;
    assign PFD_RSTb = pfd_rstb_q;
    assign CP_EN    = cp_en_q;
    assign LOCK     = lock_q;
    assign LOL      = lol_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: bring-up timing, window threshold, lock loss, overlap and aborts.
module tb_pll_lock_ctrl;

    logic       CLK = 1'b0;
    logic       RSTb = 1'b1;
    logic       EN = 1'b0;
    logic       REF_TICK = 1'b0;
    logic       UP = 1'b0;
    logic       DOWN = 1'b0;
    wire        PFD_RSTb, CP_EN, LOCK, LOL;
    wire  [2:0] STATE;
    wire        VDD, VSS;
    assign VDD = 1'b1;
    assign VSS = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    pll_lock_ctrl dut (
        .CLK(CLK), .RSTb(RSTb), .EN(EN), .REF_TICK(REF_TICK), .UP(UP), .DOWN(DOWN),
        .PFD_RSTb(PFD_RSTb), .CP_EN(CP_EN), .LOCK(LOCK), .LOL(LOL), .STATE(STATE),
        .VDD(VDD), .VSS(VSS)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic restart();
        RSTb = 1'b0; EN = 1'b0; UP = 1'b0; DOWN = 1'b0; REF_TICK = 1'b0;
        step(); step();
        RSTb = 1'b1;
        step();
    endtask

    // One 10-clock reference window; REF_TICK on the last clock. UP pulses on clocks
    // 1..n_pulse land in this window after the 2-clock synchronizer delay.
    task automatic window(input logic up_lvl, input logic dn_lvl, input int n_pulse, input logic en_tick);
        for (int i = 0; i < 10; i++) begin
            UP       = up_lvl | ((i >= 1) && (i < 1 + n_pulse));
            DOWN     = dn_lvl;
            REF_TICK = (i == 9);
            EN       = (i == 9) ? en_tick : 1'b1;
            step();
        end
        REF_TICK = 1'b0;
    endtask

    task automatic windows(input int n, input logic up_lvl, input logic dn_lvl, input int n_pulse);
        for (int w = 0; w < n; w++) window(up_lvl, dn_lvl, n_pulse, 1'b1);
    endtask

    task automatic goto_acquire(output bit ok);
        ok = 1'b0;
        EN = 1'b1;
        for (int c = 0; c < 400; c++) begin
            step();
            if (STATE == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 RSTb = 1'b0;
        #1;
        n_vec++; if ({STATE, PFD_RSTb, CP_EN, LOCK, LOL} !== 7'd0) begin n_err++; $display("FAIL reset_async act=%b exp=%b", {STATE, PFD_RSTb, CP_EN, LOCK, LOL}, 7'd0); end
        EN = 1'b1;
        step(); step();
        n_vec++; if (STATE !== 3'd0) begin n_err++; $display("FAIL reset_hold_state act=%0d exp=0", STATE); end
        EN = 1'b0;
        RSTb = 1'b1;
        step(); step();
        n_vec++; if ({STATE, PFD_RSTb, CP_EN} !== 5'd0) begin n_err++; $display("FAIL idle_en0 act=%b exp=%b", {STATE, PFD_RSTb, CP_EN}, 5'd0); end
    endtask

    task automatic test_bringup();
        int n_rst = 0, n_set = 0, bad = 0;
        bit ok = 1'b0;
        restart();
        EN = 1'b1;
        for (int c = 0; c < 400; c++) begin
            REF_TICK = (c % 10 == 9);
            step();
            if (STATE == 3'd1) begin
                n_rst++;
                if (PFD_RSTb !== 1'b0 || CP_EN !== 1'b0) bad++;
            end else if (STATE == 3'd2) begin
                n_set++;
                if (PFD_RSTb !== 1'b1 || CP_EN !== 1'b1) bad++;
            end else if (STATE == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        REF_TICK = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL bringup_reach_acquire act=%0d exp=3", STATE); end
        n_vec++; if (n_rst != 8) begin n_err++; $display("FAIL bringup_pfd_rst_len act=%0d exp=8", n_rst); end
        n_vec++; if (n_set != 256) begin n_err++; $display("FAIL bringup_settle_len act=%0d exp=256", n_set); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bringup_outputs bad_cycles=%0d exp=0", bad); end
        windows(63, 1'b0, 1'b0, 0);
        n_vec++; if ({STATE, LOCK} !== {3'd3, 1'b0}) begin n_err++; $display("FAIL bringup_63 act=%0d/%b exp=3/0", STATE, LOCK); end
        windows(1, 1'b0, 1'b0, 0);
        n_vec++; if ({STATE, LOCK, LOL} !== {3'd4, 1'b1, 1'b0}) begin n_err++; $display("FAIL bringup_lock act=%0d/%b/%b exp=4/1/0", STATE, LOCK, LOL); end
    endtask

    task automatic test_threshold();
        bit ok;
        restart();
        goto_acquire(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL thr_reach_acquire act=%0d exp=3", STATE); end
        windows(63, 1'b0, 1'b0, 2);
        n_vec++; if (STATE !== 3'd3) begin n_err++; $display("FAIL thr_63_of_2 act=%0d exp=3", STATE); end
        windows(1, 1'b0, 1'b0, 3);
        n_vec++; if (STATE !== 3'd3) begin n_err++; $display("FAIL thr_dirty3 act=%0d exp=3", STATE); end
        windows(63, 1'b0, 1'b0, 2);
        n_vec++; if ({STATE, LOCK} !== {3'd3, 1'b0}) begin n_err++; $display("FAIL thr_cleared act=%0d/%b exp=3/0", STATE, LOCK); end
        windows(1, 1'b0, 1'b0, 2);
        n_vec++; if ({STATE, LOCK} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL thr_lock act=%0d/%b exp=4/1", STATE, LOCK); end
    endtask

    task automatic test_loss_of_lock();
        bit ok;
        restart();
        goto_acquire(ok);
        windows(64, 1'b0, 1'b0, 0);
        n_vec++; if (STATE !== 3'd4) begin n_err++; $display("FAIL lol_locked act=%0d exp=4", STATE); end
        windows(3, 1'b1, 1'b0, 0);
        n_vec++; if ({STATE, LOCK, LOL} !== {3'd4, 1'b1, 1'b0}) begin n_err++; $display("FAIL lol_3dirty act=%0d/%b/%b exp=4/1/0", STATE, LOCK, LOL); end
        windows(1, 1'b0, 1'b0, 0);
        windows(3, 1'b1, 1'b0, 0);
        n_vec++; if ({STATE, LOCK} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL lol_clean_resets act=%0d/%b exp=4/1", STATE, LOCK); end
        windows(1, 1'b1, 1'b0, 0);
        n_vec++; if ({STATE, LOCK, LOL} !== {3'd3, 1'b0, 1'b1}) begin n_err++; $display("FAIL lol_pulse act=%0d/%b/%b exp=3/0/1", STATE, LOCK, LOL); end
        UP = 1'b0;
        step();
        n_vec++; if ({STATE, LOCK, LOL} !== {3'd3, 1'b0, 1'b0}) begin n_err++; $display("FAIL lol_one_cycle act=%0d/%b/%b exp=3/0/0", STATE, LOCK, LOL); end
    endtask

    task automatic test_overlap();
        bit ok;
        restart();
        goto_acquire(ok);
        windows(63, 1'b1, 1'b1, 0);
        n_vec++; if (STATE !== 3'd3) begin n_err++; $display("FAIL ovl_63 act=%0d exp=3", STATE); end
        windows(1, 1'b1, 1'b1, 0);
        n_vec++; if ({STATE, LOCK} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL ovl_lock act=%0d/%b exp=4/1", STATE, LOCK); end
        UP = 1'b0; DOWN = 1'b0;
    endtask

    task automatic test_abort_en();
        bit ok;
        restart();
        goto_acquire(ok);
        windows(63, 1'b0, 1'b0, 0);
        window(1'b0, 1'b0, 0, 1'b0);
        n_vec++; if ({STATE, LOCK, LOL, PFD_RSTb, CP_EN} !== 7'd0) begin n_err++; $display("FAIL abort_en act=%b exp=%b", {STATE, LOCK, LOL, PFD_RSTb, CP_EN}, 7'd0); end
        step();
        n_vec++; if ({STATE, LOCK} !== 4'd0) begin n_err++; $display("FAIL abort_en_hold act=%0d/%b exp=0/0", STATE, LOCK); end
    endtask

    task automatic test_abort_rst();
        restart();
        EN = 1'b1;
        for (int c = 0; c < 20; c++) step();
        n_vec++; if ({STATE, PFD_RSTb, CP_EN} !== {3'd2, 1'b1, 1'b1}) begin n_err++; $display("FAIL rst_in_settle act=%0d/%b/%b exp=2/1/1", STATE, PFD_RSTb, CP_EN); end
        #3 RSTb = 1'b0;
        #1;
        n_vec++; if ({STATE, PFD_RSTb, CP_EN, LOCK, LOL} !== 7'd0) begin n_err++; $display("FAIL rst_async act=%b exp=%b", {STATE, PFD_RSTb, CP_EN, LOCK, LOL}, 7'd0); end
        EN = 1'b0;
        step();
        RSTb = 1'b1;
        for (int c = 0; c < 5; c++) step();
        n_vec++; if (STATE !== 3'd0) begin n_err++; $display("FAIL rst_wait_en act=%0d exp=0", STATE); end
        EN = 1'b1;
        step();
        n_vec++; if ({STATE, PFD_RSTb} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL rst_restart act=%0d/%b exp=1/0", STATE, PFD_RSTb); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_threshold();
        test_loss_of_lock();
        test_overlap();
        test_abort_en();
        test_abort_rst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameters SHALL be exactly:
 RST_CYCLES, 8, clocks PFD_RSTb is held low after enable (1..255)
 SETTLE_CYCLES, 256, clocks waited with CP_EN=1 before lock counting (1..65535)
 ERR_MAX, 2, max mismatch clocks per reference window still counted as clean
 LOCK_COUNT, 64, consecutive clean windows required to declare lock (1..255)
 UNLOCK_COUNT, 4, consecutive dirty windows required to declare loss of lock (1..255)
REQ-002 Ports SHALL be exactly:
 CLK  input  1  controller clock, all logic on rising edge
 RSTb  input  1  asynchronous active-low reset
 EN  input  1  synchronous enable of the PLL bring-up sequence
 REF_TICK  input  1  synchronous one-cycle pulse marking end of each reference period
 UP  input  1  phase detector UP output, asynchronous to CLK
 DOWN  input  1  phase detector DOWN output, asynchronous to CLK
 PFD_RSTb  output  1  active-low reset to phase detector/divider
 CP_EN  output  1  charge pump enable
 LOCK  output  1  lock indication
 LOL  output  1  one-cycle loss-of-lock pulse
 STATE  output  3  current FSM state encoding
 VDD  inout  1  supply
 VSS  inout  1  ground
REQ-003 The design SHALL use one clock (CLK); reset SHALL be asynchronous and active-low (RSTb).

Function
REQ-004 UP and DOWN SHALL each pass through a 2-flop synchronizer (UP_s, DOWN_s) before any use.
REQ-005 A mismatch clock SHALL be any cycle with UP_s != DOWN_s; UP_s=DOWN_s=1 (detector reset overlap) SHALL NOT count.
REQ-006 Window error counter SHALL count mismatch clocks, saturate at ERR_MAX+1, and clear on the cycle after REF_TICK.
REQ-007 A mismatch clock coincident with REF_TICK SHALL belong to the closing window; a window is dirty when its count > ERR_MAX, else clean.
REQ-008 FSM states/encodings SHALL be IDLE=0, PFD_RST=1, SETTLE=2, ACQUIRE=3, LOCKED=4; STATE SHALL equal the registered state.
REQ-009 IDLE: PFD_RSTb=0, CP_EN=0; EN=1 -> PFD_RST next cycle.
REQ-010 PFD_RST: PFD_RSTb=0, CP_EN=0 for exactly RST_CYCLES clocks, then -> SETTLE.
REQ-011 SETTLE: PFD_RSTb=1, CP_EN=1 for exactly SETTLE_CYCLES clocks, then -> ACQUIRE; REF_TICKs ignored.
REQ-012 ACQUIRE: clean window increments clean counter, dirty window clears it; at LOCK_COUNT -> LOCKED with LOCK=1 from the next cycle.
REQ-013 LOCKED: dirty window increments dirty counter, clean window clears it; at UNLOCK_COUNT -> ACQUIRE, LOCK=0 and LOL=1 for exactly one cycle.
REQ-014 Clean/dirty counters SHALL clear on every state entry; window counter SHALL clear on entry to ACQUIRE.
REQ-015 EN=0 in any non-IDLE state SHALL force IDLE next cycle, overriding every other transition (including same-cycle lock/unlock); no LOL pulse on EN drop.
REQ-016 PFD_RSTb, CP_EN, LOCK, LOL SHALL be registered outputs, glitch-free.
REQ-017 LOCK SHALL be 1 only in LOCKED; LOL SHALL never be 1 while LOCK=1.

Reset
REQ-018 RSTb=0 SHALL immediately force STATE=IDLE, PFD_RSTb=0, CP_EN=0, LOCK=0, LOL=0, all counters and synchronizers to 0, regardless of CLK.
REQ-019 Reset assertion mid-sequence SHALL abort it; after release the sequence restarts from IDLE only when EN=1.

Verification
REQ-020 Bring-up: EN=1, UP=DOWN=0, REF_TICK every 10 clocks -> PFD_RSTb low 8 clocks, CP_EN high after, ACQUIRE after 256 clocks, LOCK=1 after 64th clean tick.
REQ-021 Threshold: in ACQUIRE, windows with exactly 2 mismatch clocks count clean; 3 mismatch clocks clear clean counter.
REQ-022 Loss of lock: in LOCKED, UP held high 4 windows -> one-cycle LOL, LOCK=0, STATE=3; 3 dirty then 1 clean -> stays LOCKED.
REQ-023 Overlap: UP=DOWN=1 for whole windows in ACQUIRE -> counted clean, lock reached.
REQ-024 Abort: EN=0 same cycle as 64th clean REF_TICK -> IDLE, LOCK stays 0; RSTb pulse in SETTLE -> all outputs reset value asynchronously.
